// File: rtl/fetch_pc.sv
// fetch_pc: instruction-fetch program counter with an in-flight request queue.
//
// Generates sequential fetch requests from the current PC, accepts redirects
// (branch, jump, trap), and tracks every outstanding request together with the
// redirect epoch it was issued under. Responses to requests from an older epoch
// are flagged as wrong-path through FP_RSP_KILL, so the queue never needs a flush.
//
// Optional feature: define FETCH_PC_MISALIGN_CHK_EN to reject redirects whose
// target is not 4-byte aligned (PC held, epoch still toggles, FP_MISALIGN pulses).
//
// Ports:
//   FP_CLK        in   clock, rising edge
//   FP_RST        in   asynchronous active-high reset
//   FP_STALL      in   hold PC, suppress new requests
//   FP_REDIR      in   redirect request
//   FP_REDIR_PC   in   redirect target
//   FP_REQ_VALID  out  fetch request valid
//   FP_REQ_PC     out  fetch request address (current PC)
//   FP_REQ_READY  in   memory accepts the request
//   FP_RSP_VALID  in   memory response for the oldest in-flight request
//   FP_RSP_PC     out  PC of the oldest in-flight request
//   FP_RSP_KILL   out  current response is wrong-path
//   FP_INFLIGHT   out  number of in-flight requests
//   FP_MISALIGN   out  registered misaligned-redirect flag
module fetch_pc #(
  parameter int unsigned         WIDTH     = 32,
  parameter logic [WIDTH-1:0]    RESET_VEC = '0,
  parameter int unsigned         INC       = 4,
  parameter int unsigned         DEPTH     = 4
) (
  input  logic                         FP_CLK,
  input  logic                         FP_RST,
  input  logic                         FP_STALL,
  input  logic                         FP_REDIR,
  input  logic [WIDTH-1:0]             FP_REDIR_PC,
  output logic                         FP_REQ_VALID,
  output logic [WIDTH-1:0]             FP_REQ_PC,
  input  logic                         FP_REQ_READY,
  input  logic                         FP_RSP_VALID,
  output logic [WIDTH-1:0]             FP_RSP_PC,
  output logic                         FP_RSP_KILL,
  output logic [$clog2(DEPTH+1)-1:0]   FP_INFLIGHT,
  output logic                         FP_MISALIGN
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             epoch_q, epoch_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Queue storage: PC and issue epoch of each outstanding request.
  logic [WIDTH-1:0] ent_pc_q [DEPTH];
  logic [DEPTH-1:0] ent_ep_q;

  logic req_valid_c;
  logic push_c;
  logic pop_c;
  logic empty_c;
  logic redir_bad_c;

  // Misaligned-redirect detection, compiled in only when the check is enabled.
`ifdef FETCH_PC_MISALIGN_CHK_EN
  logic misalign_q;

  assign redir_bad_c = FP_REDIR & (FP_REDIR_PC[1:0] != 2'b00);

  always_ff @(posedge FP_CLK or posedge FP_RST) begin
    if (FP_RST) misalign_q <= 1'b0;
    else        misalign_q <= redir_bad_c;
  end

  assign FP_MISALIGN = misalign_q;
`else
  assign redir_bad_c = 1'b0;
  assign FP_MISALIGN = 1'b0;
`endif

  // Handshake qualification; reset also suppresses requests.
  assign empty_c     = (cnt_q == '0);
  assign req_valid_c = ~FP_RST & ~FP_STALL & ~FP_REDIR & (cnt_q < CNT_W'(DEPTH));
  assign push_c      = req_valid_c & FP_REQ_READY;
  assign pop_c       = FP_RSP_VALID & ~empty_c;

  // Next-state: redirect beats handshake; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (FP_REDIR) begin
      epoch_d = ~epoch_q;
      if (!redir_bad_c) pc_d = FP_REDIR_PC;
    end else if (push_c) begin
      pc_d = pc_q + WIDTH'(INC);
    end

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge FP_CLK or posedge FP_RST) begin
    if (FP_RST) begin
      pc_q     <= RESET_VEC;
      epoch_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the count.
  always_ff @(posedge FP_CLK) begin
    if (push_c) begin
      ent_pc_q[wr_ptr_q] <= pc_q;
      ent_ep_q[wr_ptr_q] <= epoch_q;
    end
  end

  assign FP_REQ_VALID = req_valid_c;
  assign FP_REQ_PC    = pc_q;
  assign FP_RSP_PC    = ent_pc_q[rd_ptr_q];
  // An empty-queue response is always discarded.
  assign FP_RSP_KILL  = empty_c | (ent_ep_q[rd_ptr_q] != epoch_q) | FP_REDIR;
  assign FP_INFLIGHT  = cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed and randomized checks of fetch_pc against a queue-based
// reference model of the fetch/redirect/response rules.
module tb_fetch_pc;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned INC       = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam int unsigned CW        = $clog2(DEPTH+1);
`ifdef FETCH_PC_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic              FP_CLK = 1'b0;
  logic              FP_RST = 1'b1;
  logic              FP_STALL = 1'b0;
  logic              FP_REDIR = 1'b0;
  logic [WIDTH-1:0]  FP_REDIR_PC = '0;
  logic              FP_REQ_VALID;
  logic [WIDTH-1:0]  FP_REQ_PC;
  logic              FP_REQ_READY = 1'b0;
  logic              FP_RSP_VALID = 1'b0;
  logic [WIDTH-1:0]  FP_RSP_PC;
  logic              FP_RSP_KILL;
  logic [CW-1:0]     FP_INFLIGHT;
  logic              FP_MISALIGN;

  fetch_pc #(.WIDTH(WIDTH), .RESET_VEC(RESET_VEC), .INC(INC), .DEPTH(DEPTH)) dut (
    .FP_CLK      (FP_CLK),
    .FP_RST      (FP_RST),
    .FP_STALL    (FP_STALL),
    .FP_REDIR    (FP_REDIR),
    .FP_REDIR_PC (FP_REDIR_PC),
    .FP_REQ_VALID(FP_REQ_VALID),
    .FP_REQ_PC   (FP_REQ_PC),
    .FP_REQ_READY(FP_REQ_READY),
    .FP_RSP_VALID(FP_RSP_VALID),
    .FP_RSP_PC   (FP_RSP_PC),
    .FP_RSP_KILL (FP_RSP_KILL),
    .FP_INFLIGHT (FP_INFLIGHT),
    .FP_MISALIGN (FP_MISALIGN)
  );

  always #5 FP_CLK = ~FP_CLK;

  // Reference model: current PC, epoch bit, FIFO of issued (pc, epoch) pairs.
  typedef struct {
    logic [31:0] pc;
    bit          ep;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_ep;
  bit          m_mis;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RESET_VEC;
    m_ep  = 1'b0;
    m_mis = 1'b0;
    m_q.delete();
  endtask

  function automatic bit model_req_valid();
    return !FP_RST && !FP_STALL && !FP_REDIR && (m_q.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    chk("req_valid", 32'(FP_REQ_VALID), 32'(model_req_valid()));
    chk("req_pc",    FP_REQ_PC, m_pc);
    chk("inflight",  32'(FP_INFLIGHT), 32'(m_q.size()));
    chk("misalign",  32'(FP_MISALIGN), 32'(m_mis));
    if (m_q.size() > 0) begin
      chk("rsp_pc",   FP_RSP_PC, m_q[0].pc);
      chk("rsp_kill", 32'(FP_RSP_KILL), 32'((m_q[0].ep != m_ep) || FP_REDIR));
    end else if (FP_RSP_VALID) begin
      chk("rsp_kill_empty", 32'(FP_RSP_KILL), 32'(1));
    end
  endtask

  // One clock cycle: drive, check, clock, advance the model. Starts and ends at negedge.
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                      input bit ready, input bit rspv);
    bit hs;
    bit pop;
    bit next_mis;
    FP_STALL     = stall;
    FP_REDIR     = redir;
    FP_REDIR_PC  = rpc;
    FP_REQ_READY = ready;
    FP_RSP_VALID = rspv;
    #1;
    check_outputs();
    hs  = model_req_valid() && ready;
    pop = rspv && (m_q.size() > 0);
    @(posedge FP_CLK);
    next_mis = 1'b0;
    if (pop) m_q.delete(0);
    if (redir) begin
      m_ep = !m_ep;
      if (MIS_EN && (rpc[1:0] != 2'b00)) next_mis = 1'b1;
      else                                m_pc     = rpc;
    end else if (hs) begin
      m_q.push_back('{pc: m_pc, ep: m_ep});
      m_pc = m_pc + INC;
    end
    m_mis = next_mis;
    @(negedge FP_CLK);
  endtask

  task automatic set_idle();
    FP_STALL     = 1'b0;
    FP_REDIR     = 1'b0;
    FP_REDIR_PC  = '0;
    FP_REQ_READY = 1'b0;
    FP_RSP_VALID = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs();
    @(negedge FP_CLK);
    @(negedge FP_CLK);
    check_outputs();
    FP_RST = 1'b0;

    // Fill the queue from reset: 0, 4, 8, 12, then full.
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 0);
    set_idle();
    chk("full_req_valid", 32'(FP_REQ_VALID), 32'(0));
    chk("full_inflight",  32'(FP_INFLIGHT), 32'(4));
    chk("full_rsp_pc",    FP_RSP_PC, 32'h0);

    // Pop while full re-enables requests on the next cycle.
    step(0, 0, '0, 1, 1);
    set_idle();
    chk("pop_inflight",  32'(FP_INFLIGHT), 32'(3));
    chk("pop_req_valid", 32'(FP_REQ_VALID), 32'(1));
    chk("pop_req_pc",    FP_REQ_PC, 32'h10);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1);

    // Redirect with two requests outstanding.
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 1, 32'h100, 1, 0);
    set_idle();
    chk("redir_req_pc", FP_REQ_PC, 32'h100);
    chk("stale_kill0",  32'(FP_RSP_KILL), 32'(1));
    step(0, 0, '0, 0, 1);
    set_idle();
    chk("stale_kill1",  32'(FP_RSP_KILL), 32'(1));
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 0);
    set_idle();
    chk("fresh_rsp_pc",   FP_RSP_PC, 32'h100);
    chk("fresh_rsp_kill", 32'(FP_RSP_KILL), 32'(0));
    step(0, 0, '0, 0, 1);

    // Response with an empty queue is ignored.
    step(0, 0, '0, 0, 1);
    set_idle();
    chk("empty_rsp_inflight", 32'(FP_INFLIGHT), 32'(0));

    // PC wrap-around.
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, '0, 1, 0);
    set_idle();
    chk("wrap_req_pc", FP_REQ_PC, 32'h0);
    step(0, 0, '0, 0, 1);

    // Back-to-back redirects; last target wins.
    step(0, 1, 32'h200, 1, 0);
    step(0, 1, 32'h300, 1, 0);

    // Redirect during stall.
    step(1, 1, 32'h40, 1, 0);
    FP_STALL = 1'b1;
    #1;
    chk("stall_redir_pc",    FP_REQ_PC, 32'h40);
    chk("stall_redir_valid", 32'(FP_REQ_VALID), 32'(0));
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);

    // Misaligned redirect target.
    step(0, 1, 32'h102, 0, 0);
    set_idle();
    if (MIS_EN) begin
      chk("mis_pc_held", FP_REQ_PC, 32'h40);
      chk("mis_flag",    32'(FP_MISALIGN), 32'(1));
    end else begin
      chk("mis_pc_load", FP_REQ_PC, 32'h102);
      chk("mis_flag",    32'(FP_MISALIGN), 32'(0));
    end
    step(0, 0, '0, 0, 0);
    set_idle();
    chk("mis_flag_clear", 32'(FP_MISALIGN), 32'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0);
    end

    // Asynchronous reset with requests outstanding.
    set_idle();
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    set_idle();
    FP_RST = 1'b1;
    #1;
    model_reset();
    chk("async_rst_inflight", 32'(FP_INFLIGHT), 32'(0));
    check_outputs();
    @(negedge FP_CLK);
    FP_RST = 1'b0;
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits.
REQ-002 Parameter RESET_VEC, default 0: PC value after reset.
REQ-003 Parameter INC, default 4: sequential PC increment.
REQ-004 Parameter DEPTH, default 4, power of two, at least 2: in-flight request queue depth.
REQ-005 FP_CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 FP_RST  in  1  reset, asynchronous, active-high.
REQ-007 FP_STALL  in  1  hold the PC and suppress new requests.
REQ-008 FP_REDIR  in  1  redirect the PC (branch, jump or trap).
REQ-009 FP_REDIR_PC  in  WIDTH  redirect target.
REQ-010 FP_REQ_VALID  out  1  fetch request valid.
REQ-011 FP_REQ_PC  out  WIDTH  fetch request address; equals the current PC.
REQ-012 FP_REQ_READY  in  1  memory accepts the request.
REQ-013 FP_RSP_VALID  in  1  memory returns data for the oldest in-flight request.
REQ-014 FP_RSP_PC  out  WIDTH  PC of the oldest in-flight request.
REQ-015 FP_RSP_KILL  out  1  the current response is wrong-path and must be discarded.
REQ-016 FP_INFLIGHT  out  clog2(DEPTH+1)  in-flight request count.
REQ-017 FP_MISALIGN  out  1  registered misaligned-redirect flag.

Function
REQ-018 FP_REQ_VALID SHALL equal !FP_STALL & !FP_REDIR & (FP_INFLIGHT < DEPTH).
REQ-019 A request handshake occurs when FP_REQ_VALID & FP_REQ_READY; on that edge, {PC, epoch} is pushed and PC becomes PC+INC modulo 2^WIDTH (wrap-around, no flag).
REQ-020 FP_REDIR SHALL take priority over FP_STALL and over the handshake: on that edge PC becomes FP_REDIR_PC and the 1-bit epoch toggles.
REQ-021 With no redirect and no handshake, the PC holds its value.
REQ-022 FP_RSP_VALID with a non-empty queue pops the oldest entry on that edge.
REQ-023 FP_RSP_VALID with an empty queue is ignored: no pop, FP_INFLIGHT stays 0, FP_RSP_KILL is 1.
REQ-024 FP_RSP_PC SHALL show the oldest entry's PC combinationally; its value is don't-care when the queue is empty.
REQ-025 FP_RSP_KILL SHALL equal (oldest entry epoch != current epoch) | FP_REDIR.
REQ-026 A push and a pop on the same edge leave FP_INFLIGHT unchanged; the queue pointers wrap modulo DEPTH.
REQ-027 When the queue is full, FP_REQ_VALID is 0; a pop on that cycle re-enables requests from the next cycle.
REQ-028 A redirect does not flush the queue; stale entries drain and are marked by FP_RSP_KILL.
REQ-029 Back-to-back redirects SHALL each toggle the epoch; the last target wins.

Reset
REQ-030 While FP_RST is high, regardless of the clock: PC = RESET_VEC, epoch = 0, queue empty, FP_INFLIGHT = 0, FP_MISALIGN = 0.
REQ-031 During reset, FP_REQ_VALID SHALL be 0; after reset deasserts, the first request carries RESET_VEC.
REQ-032 Reset during outstanding requests discards all entries; later responses are treated as empty-queue responses (REQ-023).

Configuration
REQ-033 Macro FETCH_PC_MISALIGN_CHK_EN defined: a redirect with FP_REDIR_PC[1:0] != 0 leaves the PC unchanged, still toggles the epoch, and sets FP_MISALIGN high for exactly the following cycle.
REQ-034 Macro undefined: FP_MISALIGN is tied to 0, and every redirect target is loaded unmodified.

Verification
REQ-035 Reset, then FP_REQ_READY=1 with no responses for 5 cycles -> FP_REQ_PC sequence 0,4,8,12, then FP_REQ_VALID=0 with FP_INFLIGHT=4.
REQ-036 Queue full, then FP_RSP_VALID for 1 cycle -> FP_RSP_PC=0 that cycle, FP_INFLIGHT=3, FP_REQ_VALID=1 on the next cycle with FP_REQ_PC=16.
REQ-037 Two requests in flight, then FP_REDIR to 0x100 -> next FP_REQ_PC=0x100; both old responses give FP_RSP_KILL=1; the response for 0x100 gives FP_RSP_KILL=0.
REQ-038 PC=0xFFFFFFFC with a handshake -> next FP_REQ_PC=0x00000000.
REQ-039 FP_STALL=1 together with FP_REDIR=1 to 0x40 -> PC=0x40 and FP_REQ_VALID=0 while the stall holds.
REQ-040 With FETCH_PC_MISALIGN_CHK_EN defined, redirect to 0x102 -> PC unchanged and FP_MISALIGN=1 for one cycle; FP_RST asserted mid-stream -> FP_INFLIGHT=0 immediately, without waiting for a clock edge.
